// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, the nop encoding, fetch FSM states, default reset PC.
// No logic; latency and backpressure do not apply.
// Imported by the fetch unit and its neighbours.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] word);
        return word[6:0];
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Redirect mux for the fetch unit: jalr > jal > taken branch > sequential.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module next_pc_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] inst_pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1_data,
    input  logic              branch,
    input  logic              zero,
    input  logic              jal,
    input  logic              jalr,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] reg_rel;

    // All sums wrap modulo 2^ADDR_W.
    assign pc_plus4 = inst_pc + ADDR_W'(4);
    assign pc_rel   = inst_pc + imm;
    assign reg_rel  = (rs1_data + imm) & {{(ADDR_W-1){1'b1}}, 1'b0};

    always_comb begin
        next_pc = pc_plus4;
        if (jalr) begin
            next_pc = reg_rel;
        end else if (jal || (branch && zero)) begin
            next_pc = pc_rel;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Single-issue fetch: owns the PC, fetches one word per handshake and holds it for the decoder.
// Latency: 2 cycles per instruction with zero-wait memory (S_REQ -> S_HOLD -> S_REQ).
// Backpressure: imem_ready low stretches S_REQ; stall holds the word in S_HOLD. FETCH_MISALIGN_CHK_EN adds the misalign trap.
module inst_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              inst_valid,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic              misalign,
`endif
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic              jal,
    input  logic              jalr,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1_data
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_next;
    logic              accept;
    logic              retire;
    logic              bad_target;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .inst_pc  (inst_pc),
        .imm      (imm),
        .rs1_data (rs1_data),
        .branch   (branch),
        .zero     (zero),
        .jal      (jal),
        .jalr     (jalr),
        .pc_plus4 (pc_plus4),
        .next_pc  (target)
    );

    assign imem_addr = pc;
    assign accept    = (state == S_REQ) && imem_ready;
    // Redirect inputs only matter here; they are ignored in every other cycle.
    assign retire    = (state == S_HOLD) && inst_valid && !stall;

`ifdef FETCH_MISALIGN_CHK_EN
    assign bad_target = (target[1:0] != 2'b00);
    assign pc_next    = target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (retire && bad_target) begin
            misalign <= 1'b1;
        end
    end
`else
    assign bad_target = 1'b0;
    assign pc_next    = {target[ADDR_W-1:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_nxt = S_HOLD;
                end
            end
            // A misaligned target parks here with inst_valid low until reset.
            S_HOLD: begin
                if (retire && !bad_target) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (accept) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
        end else if (retire) begin
            inst_valid <= 1'b0;
            if (!bad_target) begin
                pc <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, wait states, stall, redirects, wrap, async reset.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jal = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1_data = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 4) ^ 32'hC0DE_0013;
    endfunction

    // Garbage on the bus unless the memory is accepting, so late capture is visible.
    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    inst_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc_plus4   (pc_plus4),
        .inst_valid (inst_valid),
`ifdef FETCH_MISALIGN_CHK_EN
        .misalign   (misalign),
`endif
        .stall      (stall),
        .branch     (branch),
        .zero       (zero),
        .jal        (jal),
        .jalr       (jalr),
        .imm        (imm),
        .rs1_data   (rs1_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        branch = 1'b0; zero = 1'b0; jal = 1'b0; jalr = 1'b0;
        imm = '0; rs1_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // From S_HOLD with imem_ready=1: retire via jalr and land in S_HOLD at addr.
    task automatic go_to(input logic [31:0] addr);
        stall = 1'b0; jalr = 1'b1; rs1_data = addr; imm = '0;
        tick();
        clear_redirect();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b1;
        tick();
        tick();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        vectors++; if (inst !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_inst got=%h exp=00000013", inst); end
        vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
`ifdef FETCH_MISALIGN_CHK_EN
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
`endif
        rst_n = 1'b1;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_req%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(i * 4)); end
            vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL seq_req_valid%0d got=%b exp=0", i, inst_valid); end
            tick();
            vectors++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL seq_hold%0d got valid=%b req=%b exp 1/0", i, inst_valid, imem_req); end
            vectors++; if (inst !== mem_word(32'(i * 4)) || inst_pc !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_inst%0d got=%h@%h exp=%h@%h", i, inst, inst_pc, mem_word(32'(i * 4)), 32'(i * 4)); end
            vectors++; if (pc_plus4 !== 32'(i * 4 + 4)) begin miscompares++; $display("FAIL seq_plus4_%0d got=%h exp=%h", i, pc_plus4, 32'(i * 4 + 4)); end
            tick();
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        imem_ready = 1'b1;
        tick();
        tick();
        imem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL wait_req%0d got=%b/%h exp=1/00000004", i, imem_req, imem_addr); end
            vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL wait_valid%0d got=%b exp=0", i, inst_valid); end
            tick();
        end
        imem_ready = 1'b1;
        vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL wait_ready_addr got=%h exp=00000004", imem_addr); end
        tick();
        vectors++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h4) || inst_pc !== 32'h4) begin miscompares++; $display("FAIL wait_capture got=%b %h@%h exp=1 %h@00000004", inst_valid, inst, inst_pc, mem_word(32'h4)); end
    endtask

    task automatic test_branch_stall();
        go_to(32'h10);
        branch = 1'b1; zero = 1'b1; imm = 32'hFFFF_FFF8; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== mem_word(32'h10)) begin miscompares++; $display("FAIL stall_hold%0d got=%b %h@%h exp=1 %h@00000010", i, inst_valid, inst, inst_pc, mem_word(32'h10)); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req%0d got=%b exp=0", i, imem_req); end
        end
        stall = 1'b0;
        tick();
        clear_redirect();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL branch_target got=%b/%h exp=1/00000008", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_redirect_ignored();
        tick();
        vectors++; if (imem_addr !== 32'hC) begin miscompares++; $display("FAIL seq_after_branch got=%h exp=0000000c", imem_addr); end
        imem_ready = 1'b0; jal = 1'b1; imm = 32'h100;
        tick();
        vectors++; if (imem_addr !== 32'hC) begin miscompares++; $display("FAIL req_ignores_jal got=%h exp=0000000c", imem_addr); end
        imem_ready = 1'b1;
        tick();
        clear_redirect();
        vectors++; if (inst_pc !== 32'hC) begin miscompares++; $display("FAIL req_ignores_inst_pc got=%h exp=0000000c", inst_pc); end
        tick();
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL jal_dropped got=%h exp=00000010", imem_addr); end
        tick();
        branch = 1'b1; zero = 1'b0; imm = 32'h40;
        tick();
        clear_redirect();
        vectors++; if (imem_addr !== 32'h14) begin miscompares++; $display("FAIL branch_not_taken got=%h exp=00000014", imem_addr); end
        tick();
    endtask

    task automatic test_jalr_priority();
        go_to(32'h20);
        vectors++; if (pc_plus4 !== 32'h24) begin miscompares++; $display("FAIL jalr_plus4 got=%h exp=00000024", pc_plus4); end
        jalr = 1'b1; jal = 1'b1; branch = 1'b1; zero = 1'b1; rs1_data = 32'h101; imm = 32'h4;
        tick();
        clear_redirect();
        vectors++; if (imem_addr !== 32'h104) begin miscompares++; $display("FAIL jalr_priority got=%h exp=00000104", imem_addr); end
        tick();
        jal = 1'b1; branch = 1'b1; zero = 1'b1; imm = 32'h1C;
        tick();
        clear_redirect();
        vectors++; if (imem_addr !== 32'h120) begin miscompares++; $display("FAIL jal_target got=%h exp=00000120", imem_addr); end
        tick();
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        vectors++; if (inst_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4 got=%h/%h exp=fffffffc/00000000", inst_pc, pc_plus4); end
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_reset_mid_req();
        tick();
        imem_ready = 1'b0;
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL midreq_pre got=%b/%h exp=1/00000004", imem_req, imem_addr); end
        rst_n = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL midreq_async got req=%b valid=%b exp 0/0", imem_req, inst_valid); end
        tick();
        rst_n = 1'b1; imem_ready = 1'b1;
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL midreq_restart got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_misalign();
        go_to(32'h8);
        jal = 1'b1; imm = 32'h2;
        tick();
        clear_redirect();
`ifdef FETCH_MISALIGN_CHK_EN
        vectors++; if (misalign !== 1'b1 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL misalign_flag got=%b valid=%b exp 1/0", misalign, inst_valid); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL misalign_parked%0d req got=%b exp=0", i, imem_req); end
            tick();
        end
        do_reset();
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_cleared got=%b exp=0", misalign); end
`else
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL align_forced got=%b/%h exp=1/00000008", imem_req, imem_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch_stall();
        test_redirect_ignored();
        test_jalr_priority();
        test_wrap();
        test_reset_mid_req();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

endmodule
